write_sequencer: RTL and testbench

- Sequences write_datapath across multi-sector ESDI write commands.
- Takes commands {start sector, count} on a stream and waits for sector_timer to reach the sector before the target.
- Arms the datapath over an AXI-lite master port (sector register, then control enable), then waits for the datapath interrupt and acknowledges it.
- Advances with wrap at sectors_per_track and returns one status response per command. Sits between the host command path and the write_datapath CSR slave.

---
 rtl/esdi_pkg.sv | 28 ++
 rtl/axil_write_master.sv | 61 ++++++
 rtl/write_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_write_sequencer.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esdi_pkg.sv
// Shared types and constants for the ESDI write sequencer and its AXI-lite write master.
package esdi_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_SECTOR,
        S_WR_SECTOR,
        S_WR_ARM,
        S_WAIT_DONE,
        S_WR_ACK,
        S_NEXT,
        S_RESP
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BRESP   = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_BADSECT = 2'd3;

    localparam logic [4:0] CSR_SECTOR_ADDR = 5'd12;
    localparam logic [4:0] CSR_CTRL_ADDR   = 5'd0;
    localparam logic [4:0] CSR_STATUS_ADDR = 5'd4;

    localparam logic [31:0] CTRL_ENABLE = 32'd1;
    localparam logic [31:0] W1C_ACK     = 32'd1;

endpackage

// File: rtl/axil_write_master.sv
// Single-beat AXI-lite write engine: launches AW and W together, drops each on its own
// handshake, then takes exactly one B response. Starts are ignored while a write is open.
module axil_write_master (
    input  logic        aclk,
    input  logic        areset,
    input  logic        i_start,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_data,
    output logic        o_done,
    output logic        o_err,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [4:0]  m_awaddr,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp
);

    logic        r_active;
    logic        r_awvalid;
    logic        r_wvalid;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic        w_bhs;

    assign m_awvalid = r_awvalid;
    assign m_wvalid  = r_wvalid;
    assign m_awaddr  = r_addr;
    assign m_wdata   = r_data;
    // B is only accepted once both request channels are finished
    assign m_bready  = r_active & ~r_awvalid & ~r_wvalid;
    assign w_bhs     = m_bready & m_bvalid;
    assign o_done    = w_bhs;
    assign o_err     = w_bhs & (m_bresp != 2'b00);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_active  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else if (!r_active) begin
            if (i_start) begin
                r_active  <= 1'b1;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_addr    <= i_addr;
                r_data    <= i_data;
            end
        end else begin
            if (r_awvalid && m_awready) r_awvalid <= 1'b0;
            if (r_wvalid && m_wready)   r_wvalid  <= 1'b0;
            if (w_bhs)                  r_active  <= 1'b0;
        end
    end

endmodule

// File: rtl/write_sequencer.sv
// Multi-sector ESDI write sequencer: arms write_datapath one sector early over AXI-lite.
// Optional WAIT_DONE watchdog enabled by defining WRITE_SEQUENCER_TIMEOUT_EN.
module write_sequencer
    import esdi_pkg::*;
#(
    parameter logic [4:0]  SECTOR_REG_ADDR = CSR_SECTOR_ADDR,
    parameter logic [4:0]  CTRL_ADDR       = CSR_CTRL_ADDR,
`ifdef WRITE_SEQUENCER_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES  = 100000,
`endif
    parameter logic [4:0]  STATUS_ADDR     = CSR_STATUS_ADDR
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_tvalid,
    output logic        cmd_tready,
    input  logic [15:0] cmd_tdata,
    output logic        rsp_tvalid,
    input  logic        rsp_tready,
    output logic [15:0] rsp_tdata,
    input  logic [7:0]  sectors_per_track,
    input  logic [7:0]  sector_number,
    input  logic        dp_interrupt,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [4:0]  m_awaddr,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    output logic        busy
);

    state_t      r_state, w_next_state;
    logic [7:0]  r_cur, r_remaining, r_done;
    logic [1:0]  r_status, w_next_status;
    logic        r_cmd_tready, r_rsp_tvalid, r_busy;
    logic        r_irq_q, r_irq_prev;
    logic        w_irq_rise, w_wr_start, w_wr_done, w_wr_err;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [7:0]  w_prev_sector, w_cur_inc;
    logic        w_timeout;

    assign cmd_tready    = r_cmd_tready;
    assign rsp_tvalid    = r_rsp_tvalid;
    assign busy          = r_busy;
    assign rsp_tdata     = {6'd0, r_status, r_done};
    assign w_prev_sector = (r_cur == 8'd0) ? sectors_per_track - 8'd1 : r_cur - 8'd1;
    assign w_cur_inc     = r_cur + 8'd1;
    assign w_irq_rise    = r_irq_q & ~r_irq_prev;

`ifdef WRITE_SEQUENCER_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;

    assign w_timeout = (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Held at zero outside WAIT_DONE, so each entry starts a fresh count
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                   r_tmo_cnt <= '0;
        else if (r_state != S_WAIT_DONE) r_tmo_cnt <= '0;
        else                          r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    axil_write_master u_axil (
        .aclk      (aclk),
        .areset    (areset),
        .i_start   (w_wr_start),
        .i_addr    (w_wr_addr),
        .i_data    (w_wr_data),
        .o_done    (w_wr_done),
        .o_err     (w_wr_err),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_awaddr  (m_awaddr),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_wdata   (m_wdata),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_bresp   (m_bresp)
    );

    always_comb begin
        w_wr_start = 1'b0;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        case (r_state)
            S_WR_SECTOR: begin
                w_wr_start = 1'b1;
                w_wr_addr  = SECTOR_REG_ADDR;
                w_wr_data  = {24'd0, r_cur};
            end
            S_WR_ARM: begin
                w_wr_start = 1'b1;
                w_wr_addr  = CTRL_ADDR;
                w_wr_data  = CTRL_ENABLE;
            end
            S_WR_ACK: begin
                w_wr_start = 1'b1;
                w_wr_addr  = STATUS_ADDR;
                w_wr_data  = W1C_ACK;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_status = r_status;
        case (r_state)
            S_IDLE: if (cmd_tvalid && r_cmd_tready) begin
                w_next_state  = S_CHECK;
                w_next_status = ST_OK;
            end
            S_CHECK: begin
                if (sectors_per_track == 8'd0 || r_cur >= sectors_per_track) begin
                    w_next_state  = S_RESP;
                    w_next_status = ST_BADSECT;
                end else if (r_remaining == 8'd0) begin
                    w_next_state  = S_RESP;
                end else begin
                    w_next_state  = S_WAIT_SECTOR;
                end
            end
            S_WAIT_SECTOR: if (sector_number == w_prev_sector) w_next_state = S_WR_SECTOR;
            S_WR_SECTOR, S_WR_ARM, S_WR_ACK: if (w_wr_done) begin
                if (w_wr_err) begin
                    w_next_state  = S_RESP;
                    w_next_status = ST_BRESP;
                end else if (r_state == S_WR_SECTOR) begin
                    w_next_state  = S_WR_ARM;
                end else if (r_state == S_WR_ARM) begin
                    w_next_state  = S_WAIT_DONE;
                end else begin
                    w_next_state  = S_NEXT;
                end
            end
            S_WAIT_DONE: begin
                if (w_irq_rise) begin
                    w_next_state  = S_WR_ACK;
                end else if (w_timeout) begin
                    w_next_state  = S_RESP;
                    w_next_status = ST_TIMEOUT;
                end
            end
            S_NEXT: w_next_state = (r_remaining == 8'd1) ? S_RESP : S_WAIT_SECTOR;
            S_RESP: if (rsp_tready && r_rsp_tvalid) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_status     <= ST_OK;
            r_cur        <= '0;
            r_remaining  <= '0;
            r_done       <= '0;
            r_cmd_tready <= 1'b0;
            r_rsp_tvalid <= 1'b0;
            r_busy       <= 1'b0;
            r_irq_q      <= 1'b0;
            r_irq_prev   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_status     <= w_next_status;
            r_cmd_tready <= (w_next_state == S_IDLE);
            r_rsp_tvalid <= (w_next_state == S_RESP);
            r_busy       <= (w_next_state != S_IDLE);
            r_irq_q      <= dp_interrupt;
            r_irq_prev   <= r_irq_q;
            if (r_state == S_IDLE && cmd_tvalid && r_cmd_tready) begin
                r_cur       <= cmd_tdata[7:0];
                r_remaining <= cmd_tdata[15:8];
                r_done      <= '0;
            end
            if (r_state == S_NEXT) begin
                r_done      <= r_done + 8'd1;
                r_remaining <= r_remaining - 8'd1;
                r_cur       <= (w_cur_inc == sectors_per_track) ? 8'd0 : w_cur_inc;
            end
        end
    end

endmodule

// File: tb/tb_write_sequencer.sv
// Directed bench for write_sequencer: AXI-lite slave model, sector timer and interrupt source.
module tb_write_sequencer;

    localparam int SECT_CYC = 64;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_tvalid = 1'b0;
    logic        cmd_tready;
    logic [15:0] cmd_tdata = '0;
    logic        rsp_tvalid;
    logic        rsp_tready = 1'b0;
    logic [15:0] rsp_tdata;
    logic [7:0]  sectors_per_track = 8'd36;
    logic [7:0]  sector_number;
    logic        dp_interrupt;
    logic        m_awvalid, m_awready;
    logic [4:0]  m_awaddr;
    logic        m_wvalid, m_wready;
    logic [31:0] m_wdata;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic        busy;

    always #5 aclk = ~aclk;

    write_sequencer #(
        .SECTOR_REG_ADDR (5'd12)
`ifdef WRITE_SEQUENCER_TIMEOUT_EN
        , .TIMEOUT_CYCLES (50)
`endif
    ) dut (
        .aclk (aclk), .areset (areset),
        .cmd_tvalid (cmd_tvalid), .cmd_tready (cmd_tready), .cmd_tdata (cmd_tdata),
        .rsp_tvalid (rsp_tvalid), .rsp_tready (rsp_tready), .rsp_tdata (rsp_tdata),
        .sectors_per_track (sectors_per_track), .sector_number (sector_number),
        .dp_interrupt (dp_interrupt),
        .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awaddr (m_awaddr),
        .m_wvalid (m_wvalid), .m_wready (m_wready), .m_wdata (m_wdata),
        .m_bvalid (m_bvalid), .m_bready (m_bready), .m_bresp (m_bresp),
        .busy (busy)
    );

    int vec = 0;
    int errs = 0;

    // write log filled by the slave model
    int          wr_n = 0;
    int          b_count = 0;
    int          cyc = 0;
    int          ctrl_b_cyc = 0;
    logic [4:0]  log_addr [0:255];
    logic [31:0] log_data [0:255];
    logic [7:0]  log_sect [0:255];
    int          log_awlen [0:255];
    int          log_wlen [0:255];

    // knobs set by the tests
    int          aw_delay = 0;
    logic [4:0]  err_addr = 5'd31;
    bit          irq_en = 1'b1;
    int          irq_delay = 20;
    int          sect_req_id = 0;
    logic [7:0]  sect_val = 8'd0;

    initial begin
        int seen_id;
        int tick;
        seen_id = 0;
        tick = 0;
        sector_number = 8'd0;
        forever begin
            @(negedge aclk);
            if (seen_id != sect_req_id) begin
                seen_id = sect_req_id;
                sector_number = sect_val;
                tick = 0;
            end else begin
                tick++;
                if (tick >= SECT_CYC) begin
                    tick = 0;
                    if (int'(sector_number) + 1 >= int'(sectors_per_track)) sector_number = 8'd0;
                    else sector_number = sector_number + 8'd1;
                end
            end
        end
    end

    initial begin
        bit got_aw, got_w, b_fire;
        logic [4:0]  a_l;
        logic [31:0] d_l;
        logic [7:0]  s_l;
        int aw_cnt, aw_hi, w_hi, irq_cnt, awlen_l, wlen_l;
        got_aw = 0; got_w = 0; b_fire = 0; a_l = '0; d_l = '0; s_l = '0;
        aw_cnt = 0; aw_hi = 0; w_hi = 0; irq_cnt = 0; awlen_l = 0; wlen_l = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; dp_interrupt = 0;
        forever begin
            @(negedge aclk);
            cyc++;
            if (areset) begin
                got_aw = 0; got_w = 0; b_fire = 0; aw_cnt = 0; aw_hi = 0; w_hi = 0; irq_cnt = 0;
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; dp_interrupt = 0;
                continue;
            end
            if (b_fire) begin
                m_bvalid = 0;
                b_fire = 0;
            end
            if (got_aw && got_w && !m_bvalid) begin
                m_bvalid = 1;
                m_bresp = (a_l == err_addr) ? 2'd2 : 2'd0;
                log_addr[wr_n] = a_l; log_data[wr_n] = d_l; log_sect[wr_n] = s_l;
                log_awlen[wr_n] = awlen_l; log_wlen[wr_n] = wlen_l;
                wr_n++;
                if (a_l == 5'd0 && d_l == 32'd1 && m_bresp == 2'd0 && irq_en) irq_cnt = irq_delay;
                if (a_l == 5'd4) dp_interrupt = 0;
                got_aw = 0; got_w = 0;
            end
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) dp_interrupt = 1;
            end
            m_awready = 0;
            if (m_awvalid && !got_aw) begin
                if (aw_hi == 0) s_l = sector_number;
                aw_hi++;
                if (aw_cnt >= aw_delay) begin
                    m_awready = 1; got_aw = 1; a_l = m_awaddr;
                    awlen_l = aw_hi; aw_hi = 0; aw_cnt = 0;
                end else aw_cnt++;
            end
            m_wready = 0;
            if (m_wvalid && !got_w) begin
                w_hi++;
                m_wready = 1; got_w = 1; d_l = m_wdata;
                wlen_l = w_hi; w_hi = 0;
            end
            b_fire = m_bvalid && m_bready;
            if (b_fire) begin
                b_count++;
                if (a_l == 5'd0) ctrl_b_cyc = cyc;
            end
        end
    end

    task automatic set_sector(input logic [7:0] s);
        @(negedge aclk);
        sect_val = s;
        sect_req_id++;
        @(negedge aclk);
    endtask

    task automatic send_cmd(input logic [7:0] start, input logic [7:0] count, output bit ok);
        @(negedge aclk);
        cmd_tdata = {count, start};
        cmd_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_tready) begin
                ok = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        @(posedge aclk);
        #1;
        cmd_tvalid = 1'b0;
    endtask

    task automatic get_rsp(input int maxc, input int hold, output logic [15:0] d,
                           output bit ok, output bit stable);
        ok = 1'b0;
        stable = 1'b1;
        d = '0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge aclk);
            if (rsp_tvalid) begin
                d = rsp_tdata;
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge aclk);
                if (rsp_tdata !== d || rsp_tvalid !== 1'b1 || cmd_tready !== 1'b0) stable = 1'b0;
            end
            rsp_tready = 1'b1;
            @(posedge aclk);
            #1;
            rsp_tready = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge aclk);
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        vec++;
        if ({cmd_tready, busy, m_awvalid, m_wvalid, m_bready, rsp_tvalid} !== 6'b0) begin
            errs++;
            $display("FAIL reset_ctrl: got %b, want 000000",
                     {cmd_tready, busy, m_awvalid, m_wvalid, m_bready, rsp_tvalid});
        end
        vec++;
        if ({m_awaddr, m_wdata, rsp_tdata} !== 53'd0) begin
            errs++;
            $display("FAIL reset_data: awaddr %0d wdata %0h rsp %h, want 0", m_awaddr, m_wdata, rsp_tdata);
        end
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        vec++;
        if (cmd_tready !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_release: cmd_tready %b busy %b, want 1 0", cmd_tready, busy);
        end
    endtask

    task automatic test_single();
        logic [15:0] d;
        bit ok, okr, st;
        int base;
        sectors_per_track = 8'd36;
        set_sector(8'd3);
        base = wr_n;
        send_cmd(8'd5, 8'd1, ok);
        get_rsp(2000, 3, d, okr, st);
        vec++;
        if (!ok || !okr || d !== 16'h0001) begin
            errs++;
            $display("FAIL single_rsp: got %h (acc %0d rsp %0d), want 0001", d, ok, okr);
        end
        vec++;
        if (!st) begin
            errs++;
            $display("FAIL single_rsp_hold: response not stable or cmd accepted, want stable");
        end
        vec++;
        if (wr_n - base !== 3) begin
            errs++;
            $display("FAIL single_count: got %0d writes, want 3", wr_n - base);
        end else begin
            vec++;
            if ({log_addr[base], log_data[base], log_addr[base+1], log_data[base+1],
                 log_addr[base+2], log_data[base+2]} !== {5'd12, 32'd5, 5'd0, 32'd1, 5'd4, 32'd1}) begin
                errs++;
                $display("FAIL single_writes: got (%0d,%0d)(%0d,%0d)(%0d,%0d), want (12,5)(0,1)(4,1)",
                         log_addr[base], log_data[base], log_addr[base+1], log_data[base+1],
                         log_addr[base+2], log_data[base+2]);
            end
        end
        @(negedge aclk);
        vec++;
        if (busy !== 1'b0 || cmd_tready !== 1'b1) begin
            errs++;
            $display("FAIL single_idle: busy %b cmd_tready %b, want 0 1", busy, cmd_tready);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        bit ok, okr, st;
        int base;
        sectors_per_track = 8'd36;
        set_sector(8'd30);
        base = wr_n;
        send_cmd(8'd35, 8'd3, ok);
        get_rsp(3000, 0, d, okr, st);
        vec++;
        if (!okr || d !== 16'h0003) begin
            errs++;
            $display("FAIL wrap_rsp: got %h, want 0003", d);
        end
        vec++;
        if (wr_n - base !== 9) begin
            errs++;
            $display("FAIL wrap_count: got %0d writes, want 9", wr_n - base);
        end else begin
            vec++;
            if ({log_data[base][7:0], log_data[base+3][7:0], log_data[base+6][7:0]} !== {8'd35, 8'd0, 8'd1}) begin
                errs++;
                $display("FAIL wrap_armed: got %0d %0d %0d, want 35 0 1",
                         log_data[base], log_data[base+3], log_data[base+6]);
            end
            vec++;
            if ({log_sect[base], log_sect[base+3], log_sect[base+6]} !== {8'd34, 8'd35, 8'd0}) begin
                errs++;
                $display("FAIL wrap_exit_sector: got %0d %0d %0d, want 34 35 0",
                         log_sect[base], log_sect[base+3], log_sect[base+6]);
            end
        end
    endtask

    task automatic test_check();
        logic [15:0] d;
        bit ok, okr, st;
        int base;
        sectors_per_track = 8'd36;
        base = wr_n;
        send_cmd(8'd40, 8'd2, ok);
        get_rsp(200, 0, d, okr, st);
        vec++;
        if (!okr || d !== 16'h0300) begin
            errs++;
            $display("FAIL bad_sector_rsp: got %h, want 0300", d);
        end
        send_cmd(8'd36, 8'd1, ok);
        get_rsp(200, 0, d, okr, st);
        vec++;
        if (!okr || d !== 16'h0300) begin
            errs++;
            $display("FAIL edge_sector_rsp: got %h, want 0300", d);
        end
        send_cmd(8'd7, 8'd0, ok);
        get_rsp(200, 0, d, okr, st);
        vec++;
        if (!okr || d !== 16'h0000) begin
            errs++;
            $display("FAIL zero_count_rsp: got %h, want 0000", d);
        end
        sectors_per_track = 8'd0;
        send_cmd(8'd0, 8'd1, ok);
        get_rsp(200, 0, d, okr, st);
        vec++;
        if (!okr || d !== 16'h0300) begin
            errs++;
            $display("FAIL zero_spt_rsp: got %h, want 0300", d);
        end
        sectors_per_track = 8'd36;
        vec++;
        if (wr_n - base !== 0) begin
            errs++;
            $display("FAIL check_no_axi: got %0d writes, want 0", wr_n - base);
        end
    endtask

    task automatic test_bresp();
        logic [15:0] d;
        bit ok, okr, st;
        int base;
        set_sector(8'd3);
        err_addr = 5'd0;
        base = wr_n;
        send_cmd(8'd5, 8'd1, ok);
        get_rsp(2000, 0, d, okr, st);
        err_addr = 5'd31;
        vec++;
        if (!okr || d !== 16'h0100 || wr_n - base !== 2) begin
            errs++;
            $display("FAIL bresp_rsp: got %h after %0d writes, want 0100 after 2", d, wr_n - base);
        end
        base = wr_n;
        send_cmd(8'd5, 8'd1, ok);
        get_rsp(3000, 0, d, okr, st);
        vec++;
        if (!ok || !okr || d !== 16'h0001 || wr_n - base !== 3) begin
            errs++;
            $display("FAIL bresp_recover: got %h after %0d writes, want 0001 after 3", d, wr_n - base);
        end
    endtask

    task automatic test_aw_delay();
        logic [15:0] d;
        bit ok, okr, st;
        int base, bbase;
        set_sector(8'd3);
        aw_delay = 3;
        base = wr_n;
        bbase = b_count;
        send_cmd(8'd5, 8'd1, ok);
        get_rsp(2000, 0, d, okr, st);
        aw_delay = 0;
        vec++;
        if (!okr || d !== 16'h0001) begin
            errs++;
            $display("FAIL awdelay_rsp: got %h, want 0001", d);
        end
        vec++;
        if (log_awlen[base] !== 4 || log_wlen[base] !== 1) begin
            errs++;
            $display("FAIL awdelay_valids: awvalid %0d cycles wvalid %0d cycles, want 4 1",
                     log_awlen[base], log_wlen[base]);
        end
        vec++;
        if (b_count - bbase !== 3 || wr_n - base !== 3) begin
            errs++;
            $display("FAIL awdelay_b: got %0d B for %0d writes, want 3 3", b_count - bbase, wr_n - base);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        bit ok, okr, st;
        int base, lat;
        set_sector(8'd3);
        irq_en = 1'b0;
        base = wr_n;
        send_cmd(8'd5, 8'd1, ok);
`ifdef WRITE_SEQUENCER_TIMEOUT_EN
        get_rsp(2000, 0, d, okr, st);
        lat = cyc - ctrl_b_cyc;
        vec++;
        if (!okr || d !== 16'h0200 || wr_n - base !== 2) begin
            errs++;
            $display("FAIL timeout_rsp: got %h after %0d writes, want 0200 after 2", d, wr_n - base);
        end
        vec++;
        if (lat < 48 || lat > 53) begin
            errs++;
            $display("FAIL timeout_latency: got %0d cycles, want about 50", lat);
        end
`else
        get_rsp(400, 0, d, okr, st);
        lat = wr_n - base;
        vec++;
        if (okr || busy !== 1'b1 || lat !== 2) begin
            errs++;
            $display("FAIL no_timeout_wait: rsp %0d busy %b writes %0d, want 0 1 2", okr, busy, lat);
        end
        pulse_reset();
`endif
        irq_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        sectors_per_track = 8'd36;
        set_sector(8'd10);
        send_cmd(8'd5, 8'd1, ok);
        repeat (20) @(negedge aclk);
        vec++;
        if (!ok || busy !== 1'b1) begin
            errs++;
            $display("FAIL midreset_busy: busy %b, want 1", busy);
        end
        areset = 1'b1;
        @(negedge aclk);
        vec++;
        if ({cmd_tready, busy, m_awvalid, m_wvalid, rsp_tvalid} !== 5'b0) begin
            errs++;
            $display("FAIL midreset_hold: got %b, want 00000",
                     {cmd_tready, busy, m_awvalid, m_wvalid, rsp_tvalid});
        end
        @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        vec++;
        if (cmd_tready !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL midreset_release: cmd_tready %b busy %b, want 1 0", cmd_tready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_check();
        test_bresp();
        test_aw_delay();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
